ray_column_sequencer: RTL and testbench
=======================================

Name: ray_column_sequencer

Overview:
Sequences the per-column ray-setup datapath across one frame.
- On a frame request, snapshots the player pose (pos/dir/plane) so it is stable for the whole frame.
- Steps hcount 0..SCREEN_WIDTH-1, pulsing tabulate for each column, then waits for the ray calculator's valid.
- Grants the calculator's output handshake only when the downstream DDA FIFO has room; reports frame completion and error conditions.
- Sits between the frame/controller logic and the ray-calculation stage.

Parameters:
SCREEN_WIDTH, 320, columns per frame
HCOUNT_WIDTH, 9, width of column index
POSE_WIDTH, 16, width of each pose component (Q8.8)
TIMEOUT_CYCLES, 64, max cycles in WAIT_CALC before abort
TIMEOUT_WIDTH, 7, watchdog counter width (must hold TIMEOUT_CYCLES)

Ports:
pixel_clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
frame_start_in  in  1  one-cycle frame request
clear_err_in  in  1  clears sticky error flags
posX_in, posY_in, dirX_in, dirY_in, planeX_in, planeY_in  in  POSE_WIDTH each  live pose from controller
calc_valid_in  in  1  ray calculator valid_out
calc_hcount_in  in  HCOUNT_WIDTH  ray calculator hcount_out
fifo_full_in  in  1  downstream DDA FIFO full
posX_out, posY_out, dirX_out, dirY_out, planeX_out, planeY_out  out  POSE_WIDTH each  frame-stable pose snapshot
hcount_out  out  HCOUNT_WIDTH  current column
tabulate_out  out  1  start pulse to ray calculator
dda_data_ready_out  out  1  ready to ray calculator
busy_out  out  1  frame in progress
frame_done_out  out  1  one-cycle end-of-frame pulse
timeout_err_out  out  1  sticky watchdog abort
seq_err_out  out  1  sticky hcount mismatch
overrun_err_out  out  1  sticky frame_start while busy

Behaviour:
- Clock and reset: one clock, pixel_clk_in. Reset is synchronous, active-high, on rst_in.
- Reset values: state IDLE; all outputs 0, including pose snapshots, hcount_out and the sticky flags.
- States:
  - IDLE: on frame_start_in, register all six pose inputs into *_out, set hcount_out=0, go to ISSUE.
  - ISSUE: tabulate_out=1 for exactly this one cycle; clear watchdog; go to WAIT_CALC.
  - WAIT_CALC: dda_data_ready_out = !fifo_full_in (combinational from state and fifo_full_in). Transfer occurs on the cycle where calc_valid_in && dda_data_ready_out.
    - On transfer, if calc_hcount_in != hcount_out, set seq_err_out (no other effect).
    - On transfer, go to SETTLE.
    - Watchdog increments every WAIT_CALC cycle without a transfer, including fifo_full stalls. On reaching TIMEOUT_CYCLES: set timeout_err_out and go to DONE (frame abort).
  - SETTLE: one cycle; calc_valid_in is ignored here, because the calculator's registered valid may linger one cycle.
    - If hcount_out == SCREEN_WIDTH-1, go to DONE.
    - Otherwise increment hcount_out and go to ISSUE.
  - DONE: frame_done_out=1 for one cycle; go to IDLE.
- busy_out=1 in every state except IDLE.
- Latency:
  - frame_start at cycle N: tabulate_out at N+1.
  - Transfer at cycle T: next tabulate_out at T+2.
  - Last transfer at T: frame_done_out at T+2.
- Pose inputs are ignored outside the IDLE capture cycle; a mid-frame pose change never alters *_out.
- frame_start_in outside IDLE, including DONE: ignored, and sets overrun_err_out.
- clear_err_in clears all three sticky flags. If an error event occurs in the same cycle, the set wins.
- dda_data_ready_out=0 in every state other than WAIT_CALC.
- rst_in mid-frame returns to IDLE with the full reset values within the same cycle edge. No frame_done_out is emitted.
- hcount never wraps: SCREEN_WIDTH-1 is terminal.

Decomposition:
- Shared package ray_pkg holds:
  - the state enum type (IDLE, ISSUE, WAIT_CALC, SETTLE, DONE);
  - constants SCREEN_WIDTH and HCOUNT_WIDTH, shared with the ray calculator and DDA;
  - the Q8.8 pose_t typedef.
- One natural sub-module: pose_snapshot_reg, a six-field load-enable register bank.
- Watchdog and FSM stay inline.

Test Plan:
- Full frame; calc model returns valid 20 cycles after each tabulate with matching hcount; fifo_full=0 -> exactly 320 tabulate pulses, hcount 0..319 in order, frame_done_out once, at 2 cycles after the final transfer; no error flags.
- Backpressure: fifo_full_in=1 for 30 cycles while calc_valid_in=1 at column 5 -> dda_data_ready_out=0 throughout; hcount_out holds at 5; transfer in the cycle fifo_full drops; no timeout.
- Pose stability: frame_start with posX_in=0x0380, then posX_in=0x0900 mid-frame -> posX_out stays 0x0380 all frame. The next frame captures 0x0900.
- Timeout: calc never asserts valid at column 10 -> after 64 WAIT_CALC cycles, timeout_err_out=1, frame_done_out pulses, busy_out=0. clear_err_in then clears the flag.
- Errors: frame_start_in during column 3 -> overrun_err_out=1 and the frame continues normally. Calc returns hcount 7 while hcount_out=6 -> seq_err_out=1.
- Reset mid-frame at column 100 -> next cycle all outputs 0, state IDLE. A following frame_start_in restarts at hcount 0.

Source files
------------

// File: rtl/ray_pkg.sv
// Shared ray-pipeline types and sizes: sequencer states, screen geometry, Q8.8 pose word.
package ray_pkg;

  localparam int SCREEN_WIDTH = 320;
  localparam int HCOUNT_WIDTH = 9;
  localparam int POSE_WIDTH   = 16;

  typedef logic signed [POSE_WIDTH-1:0] pose_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_CALC,
    SETTLE,
    DONE
  } seq_state_t;

endpackage

// File: rtl/pose_snapshot_reg.sv
// Six-field load-enable register bank holding the frame-stable player pose.
// Loads in one cycle when i_load is high; holds otherwise; no backpressure.
module pose_snapshot_reg
  import ray_pkg::*;
#(
  parameter int W = POSE_WIDTH
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_pos_x,
  input  logic [W-1:0] i_pos_y,
  input  logic [W-1:0] i_dir_x,
  input  logic [W-1:0] i_dir_y,
  input  logic [W-1:0] i_plane_x,
  input  logic [W-1:0] i_plane_y,
  output logic [W-1:0] o_pos_x,
  output logic [W-1:0] o_pos_y,
  output logic [W-1:0] o_dir_x,
  output logic [W-1:0] o_dir_y,
  output logic [W-1:0] o_plane_x,
  output logic [W-1:0] o_plane_y
);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pos_x   <= '0;
      o_pos_y   <= '0;
      o_dir_x   <= '0;
      o_dir_y   <= '0;
      o_plane_x <= '0;
      o_plane_y <= '0;
    end else if (i_load) begin
      o_pos_x   <= i_pos_x;
      o_pos_y   <= i_pos_y;
      o_dir_x   <= i_dir_x;
      o_dir_y   <= i_dir_y;
      o_plane_x <= i_plane_x;
      o_plane_y <= i_plane_y;
    end
  end

endmodule

// File: rtl/ray_column_sequencer.sv
// Steps one frame of columns through the ray calculator; tabulate 1 cycle after frame_start,
// next column 2 cycles after each transfer; the transfer is held off while the DDA FIFO is full.
module ray_column_sequencer #(
  parameter int SCREEN_WIDTH   = ray_pkg::SCREEN_WIDTH,
  parameter int HCOUNT_WIDTH   = ray_pkg::HCOUNT_WIDTH,
  parameter int POSE_WIDTH     = ray_pkg::POSE_WIDTH,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TIMEOUT_WIDTH  = 7
) (
  input  logic                    pixel_clk_in,
  input  logic                    rst_in,
  input  logic                    frame_start_in,
  input  logic                    clear_err_in,
  input  logic [POSE_WIDTH-1:0]   posX_in,
  input  logic [POSE_WIDTH-1:0]   posY_in,
  input  logic [POSE_WIDTH-1:0]   dirX_in,
  input  logic [POSE_WIDTH-1:0]   dirY_in,
  input  logic [POSE_WIDTH-1:0]   planeX_in,
  input  logic [POSE_WIDTH-1:0]   planeY_in,
  input  logic                    calc_valid_in,
  input  logic [HCOUNT_WIDTH-1:0] calc_hcount_in,
  input  logic                    fifo_full_in,
  output logic [POSE_WIDTH-1:0]   posX_out,
  output logic [POSE_WIDTH-1:0]   posY_out,
  output logic [POSE_WIDTH-1:0]   dirX_out,
  output logic [POSE_WIDTH-1:0]   dirY_out,
  output logic [POSE_WIDTH-1:0]   planeX_out,
  output logic [POSE_WIDTH-1:0]   planeY_out,
  output logic [HCOUNT_WIDTH-1:0] hcount_out,
  output logic                    tabulate_out,
  output logic                    dda_data_ready_out,
  output logic                    busy_out,
  output logic                    frame_done_out,
  output logic                    timeout_err_out,
  output logic                    seq_err_out,
  output logic                    overrun_err_out
);

  import ray_pkg::*;

  seq_state_t                r_state;
  seq_state_t                w_state_next;
  logic [HCOUNT_WIDTH-1:0]   r_hcount;
  logic [TIMEOUT_WIDTH-1:0]  r_wdog;
  logic [TIMEOUT_WIDTH-1:0]  w_wdog_inc;
  logic                      r_timeout_err;
  logic                      r_seq_err;
  logic                      r_overrun_err;
  logic                      w_pose_load;
  logic                      w_xfer;
  logic                      w_timeout;
  logic                      w_last_col;

  assign w_wdog_inc = r_wdog + 1'b1;
  assign w_last_col = (r_hcount == HCOUNT_WIDTH'(SCREEN_WIDTH - 1));

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next       = r_state;
    w_pose_load        = 1'b0;
    w_xfer             = 1'b0;
    w_timeout          = 1'b0;
    tabulate_out       = 1'b0;
    dda_data_ready_out = 1'b0;
    frame_done_out     = 1'b0;
    busy_out           = 1'b1;
    case (r_state)
      IDLE: begin
        busy_out = 1'b0;
        if (frame_start_in) begin
          w_pose_load  = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        tabulate_out = 1'b1;
        w_state_next = WAIT_CALC;
      end
      WAIT_CALC: begin
        dda_data_ready_out = !fifo_full_in;
        w_xfer             = calc_valid_in && !fifo_full_in;
        if (w_xfer) begin
          w_state_next = SETTLE;
        end else if (w_wdog_inc == TIMEOUT_WIDTH'(TIMEOUT_CYCLES)) begin
          w_timeout    = 1'b1;
          w_state_next = DONE;
        end
      end
      // Calculator valid may linger one cycle after the transfer; it is not looked at here.
      SETTLE: w_state_next = w_last_col ? DONE : ISSUE;
      DONE: begin
        frame_done_out = 1'b1;
        w_state_next   = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_hcount      <= '0;
      r_wdog        <= '0;
      r_timeout_err <= 1'b0;
      r_seq_err     <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      if (w_pose_load)
        r_hcount <= '0;
      else if (r_state == SETTLE && !w_last_col)
        r_hcount <= r_hcount + 1'b1;

      if (r_state == ISSUE)
        r_wdog <= '0;
      else if (r_state == WAIT_CALC && !w_xfer)
        r_wdog <= w_wdog_inc;

      // Error events take priority over a simultaneous clear.
      if (w_timeout)         r_timeout_err <= 1'b1;
      else if (clear_err_in) r_timeout_err <= 1'b0;

      if (w_xfer && calc_hcount_in != r_hcount) r_seq_err <= 1'b1;
      else if (clear_err_in)                    r_seq_err <= 1'b0;

      if (frame_start_in && r_state != IDLE) r_overrun_err <= 1'b1;
      else if (clear_err_in)                 r_overrun_err <= 1'b0;
    end
  end

  assign hcount_out      = r_hcount;
  assign timeout_err_out = r_timeout_err;
  assign seq_err_out     = r_seq_err;
  assign overrun_err_out = r_overrun_err;

  pose_snapshot_reg #(
    .W(POSE_WIDTH)
  ) u_pose (
    .i_clk     (pixel_clk_in),
    .i_rst     (rst_in),
    .i_load    (w_pose_load),
    .i_pos_x   (posX_in),
    .i_pos_y   (posY_in),
    .i_dir_x   (dirX_in),
    .i_dir_y   (dirY_in),
    .i_plane_x (planeX_in),
    .i_plane_y (planeY_in),
    .o_pos_x   (posX_out),
    .o_pos_y   (posY_out),
    .o_dir_x   (dirX_out),
    .o_dir_y   (dirY_out),
    .o_plane_x (planeX_out),
    .o_plane_y (planeY_out)
  );

endmodule

// File: tb/tb_ray_column_sequencer.sv
// Directed bench for ray_column_sequencer: full frame, backpressure, pose capture, errors, reset.
module tb_ray_column_sequencer;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        frame_start_in = 1'b0;
  logic        clear_err_in = 1'b0;
  logic [15:0] posX_in = 16'h0000;
  logic [15:0] posY_in = 16'h0000;
  logic [15:0] dirX_in = 16'h0000;
  logic [15:0] dirY_in = 16'h0000;
  logic [15:0] planeX_in = 16'h0000;
  logic [15:0] planeY_in = 16'h0000;
  logic        calc_valid_in = 1'b0;
  logic [8:0]  calc_hcount_in = 9'd0;
  logic        fifo_full_in = 1'b0;
  logic [15:0] posX_out, posY_out, dirX_out, dirY_out, planeX_out, planeY_out;
  logic [8:0]  hcount_out;
  logic        tabulate_out, dda_data_ready_out, busy_out, frame_done_out;
  logic        timeout_err_out, seq_err_out, overrun_err_out;

  int checks = 0;
  int failures = 0;
  int tab_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  ray_column_sequencer dut (
    .pixel_clk_in       (clk),
    .rst_in             (rst_in),
    .frame_start_in     (frame_start_in),
    .clear_err_in       (clear_err_in),
    .posX_in            (posX_in),
    .posY_in            (posY_in),
    .dirX_in            (dirX_in),
    .dirY_in            (dirY_in),
    .planeX_in          (planeX_in),
    .planeY_in          (planeY_in),
    .calc_valid_in      (calc_valid_in),
    .calc_hcount_in     (calc_hcount_in),
    .fifo_full_in       (fifo_full_in),
    .posX_out           (posX_out),
    .posY_out           (posY_out),
    .dirX_out           (dirX_out),
    .dirY_out           (dirY_out),
    .planeX_out         (planeX_out),
    .planeY_out         (planeY_out),
    .hcount_out         (hcount_out),
    .tabulate_out       (tabulate_out),
    .dda_data_ready_out (dda_data_ready_out),
    .busy_out           (busy_out),
    .frame_done_out     (frame_done_out),
    .timeout_err_out    (timeout_err_out),
    .seq_err_out        (seq_err_out),
    .overrun_err_out    (overrun_err_out)
  );

  always @(negedge clk) begin
    if (tabulate_out)   tab_cnt++;
    if (frame_done_out) done_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle boundary; one-cycle pulse inputs drop here.
  task automatic step();
    @(negedge clk);
    frame_start_in = 1'b0;
    clear_err_in   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_posX"}, posX_out, 0);
    check({tag, "_planeY"}, planeY_out, 0);
    check({tag, "_hcount"}, hcount_out, 0);
    check({tag, "_tab"}, tabulate_out, 0);
    check({tag, "_ready"}, dda_data_ready_out, 0);
    check({tag, "_busy"}, busy_out, 0);
    check({tag, "_done"}, frame_done_out, 0);
    check({tag, "_errs"}, {timeout_err_out, seq_err_out, overrun_err_out}, 0);
  endtask

  // Pulses frame_start from IDLE and checks tabulate appears on the following cycle.
  task automatic start_frame(input string tag);
    step();
    frame_start_in = 1'b1;
    #1;
    check({tag, "_start_idle"}, busy_out, 0);
    step();
    #1;
    check({tag, "_first_tab"}, tabulate_out, 1);
    check({tag, "_first_hcount"}, hcount_out, 0);
  endtask

  // Called in a tabulate cycle. Calc valid rises 'delay' cycles later, FIFO is full for
  // 'full_n' cycles from then, valid lingers through SETTLE. Returns at transfer+2.
  task automatic column(input int delay, input logic [8:0] ret_hc, input int full_n,
                        output int stall_obs);
    int k;
    bit xfer;
    logic [8:0] hc_hold;
    hc_hold = hcount_out;
    for (int i = 1; i <= delay; i++) begin
      step();
      calc_valid_in  = (i == delay);
      calc_hcount_in = ret_hc;
      fifo_full_in   = (i == delay) && (full_n > 0);
      #1;
    end
    k = 0;
    xfer = 1'b0;
    while (!xfer && k < 200) begin
      if (calc_valid_in && dda_data_ready_out) begin
        xfer = 1'b1;
      end else begin
        if (fifo_full_in) begin
          check("bp_ready_low", dda_data_ready_out, 0);
          check("bp_hcount_hold", hcount_out, hc_hold);
        end
        step();
        k++;
        fifo_full_in = (k < full_n);
        #1;
      end
    end
    check("xfer_seen", xfer, 1);
    stall_obs = k;
    step();
    fifo_full_in = 1'b0;
    #1;
    check("settle_ready_low", dda_data_ready_out, 0);
    check("settle_no_tab", tabulate_out, 0);
    step();
    calc_valid_in = 1'b0;
    #1;
  endtask

  initial begin
    int st;
    int tab_base;
    int done_base;

    posX_in = 16'h0111; posY_in = 16'h0222; dirX_in = 16'hFF00;
    dirY_in = 16'h0080; planeX_in = 16'h00A8; planeY_in = 16'hFF58;
    repeat (3) step();
    rst_in = 1'b0;
    #1;
    check_all_zero("reset");

    // Frame 1: full frame with 20-cycle calc latency.
    tab_base  = tab_cnt;
    done_base = done_cnt;
    start_frame("f1");
    check("f1_posY", posY_out, 16'h0222);
    check("f1_planeY", planeY_out, 16'hFF58);
    for (int c = 0; c < 320; c++) begin
      check("f1_hcount", hcount_out, c);
      column(20, 9'(c), 0, st);
      if (c < 319) check("f1_next_tab", tabulate_out, 1);
      else         check("f1_done_at_t2", frame_done_out, 1);
    end
    check("f1_done_busy", busy_out, 1);
    step();
    #1;
    check("f1_idle_busy", busy_out, 0);
    check("f1_done_once_pulse", frame_done_out, 0);
    check("f1_tab_count", tab_cnt - tab_base, 320);
    check("f1_done_count", done_cnt - done_base, 1);
    check("f1_errs", {timeout_err_out, seq_err_out, overrun_err_out}, 0);

    // Frame 2: pose stability, overrun, set-over-clear, backpressure, sequence error.
    posX_in   = 16'h0380;
    done_base = done_cnt;
    start_frame("f2");
    posX_in = 16'h0900;
    for (int c = 0; c < 320; c++) begin
      logic [8:0] ret;
      check("f2_posX_stable", posX_out, 16'h0380);
      check("f2_hcount", hcount_out, c);
      if (c == 3) frame_start_in = 1'b1;
      if (c == 4) begin
        frame_start_in = 1'b1;
        clear_err_in   = 1'b1;
      end
      ret = (c == 6) ? 9'd7 : 9'(c);
      column((c == 5) ? 20 : 1, ret, (c == 5) ? 30 : 0, st);
      if (c == 3) check("f2_overrun_set", overrun_err_out, 1);
      if (c == 4) check("f2_set_beats_clear", overrun_err_out, 1);
      if (c == 5) begin
        check("f2_bp_xfer_on_drop", st, 30);
        check("f2_bp_no_timeout", timeout_err_out, 0);
        check("f2_no_seq_before", seq_err_out, 0);
      end
      if (c == 6) check("f2_seq_err", seq_err_out, 1);
      if (c < 319) check("f2_next_tab", tabulate_out, 1);
      else         check("f2_done_at_t2", frame_done_out, 1);
    end
    step();
    #1;
    check("f2_done_count", done_cnt - done_base, 1);
    check("f2_errs", {timeout_err_out, seq_err_out, overrun_err_out}, 3'b011);
    step();
    clear_err_in = 1'b1;
    #1;
    step();
    #1;
    check("f2_cleared", {timeout_err_out, seq_err_out, overrun_err_out}, 0);

    // Frame 3: new pose captured; watchdog abort at column 10.
    start_frame("f3");
    check("f3_posX_new", posX_out, 16'h0900);
    for (int c = 0; c < 10; c++) column(1, 9'(c), 0, st);
    check("f3_col10_tab", tabulate_out, 1);
    check("f3_col10_hcount", hcount_out, 10);
    for (int i = 1; i <= 64; i++) begin
      step();
      #1;
    end
    check("f3_wait_busy", busy_out, 1);
    check("f3_no_timeout_yet", timeout_err_out, 0);
    step();
    #1;
    check("f3_abort_done", frame_done_out, 1);
    check("f3_timeout_set", timeout_err_out, 1);
    step();
    #1;
    check("f3_idle_busy", busy_out, 0);
    check("f3_timeout_sticky", timeout_err_out, 1);
    clear_err_in = 1'b1;
    step();
    #1;
    check("f3_timeout_cleared", timeout_err_out, 0);

    // Frame 4: reset during column 100 discards the frame without a done pulse.
    start_frame("f4");
    for (int c = 0; c < 100; c++) column(1, 9'(c), 0, st);
    check("f4_col100_hcount", hcount_out, 100);
    frame_start_in = 1'b1;
    step();
    rst_in = 1'b1;
    #1;
    check("f4_overrun_before_rst", overrun_err_out, 1);
    done_base = done_cnt;
    step();
    rst_in = 1'b0;
    #1;
    check_all_zero("f4_rst");
    repeat (3) step();
    #1;
    check("f4_no_done", done_cnt - done_base, 0);
    start_frame("f4_restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
